// File: rtl/usb_tx_ep_sched_if.sv
// Core transmit port plus the three endpoint TX FIFO ports of the IN scheduler.
// The scheduler uses the slave modport; the core/FIFO side uses master.
interface usb_tx_ep_sched_if #(
    parameter int CNT_W = 11
);
    logic [3:0]             endpt_i;
    logic                   txact_i;
    logic                   txpop_i;
    logic                   ack_received_i;
    logic                   ack_tout_i;
    logic [3*(CNT_W+1)-1:0] ep_rnum_i;
    logic [2:0]             ep_rempty_i;
    logic [2:0]             ep_ena_i;
    logic [2:0]             ep_eot_i;
    logic [2:0]             ep_rena_o;
    logic [1:0]             sel_o;
    logic                   txcork_o;
    logic [11:0]            txdat_len_o;
    logic [2:0]             pkt_done_o;
    logic [2:0]             pkt_err_o;

    modport slave (
        input  endpt_i, txact_i, txpop_i, ack_received_i, ack_tout_i,
        input  ep_rnum_i, ep_rempty_i, ep_ena_i, ep_eot_i,
        output ep_rena_o, sel_o, txcork_o, txdat_len_o, pkt_done_o, pkt_err_o
    );

    modport master (
        output endpt_i, txact_i, txpop_i, ack_received_i, ack_tout_i,
        output ep_rnum_i, ep_rempty_i, ep_ena_i, ep_eot_i,
        input  ep_rena_o, sel_o, txcork_o, txdat_len_o, pkt_done_o, pkt_err_o
    );
endinterface

// File: rtl/usb_tx_ep_sched.sv
// IN-transfer scheduler: corks/uncorks the USB core per polled endpoint slot and routes pops.
// Optional zero-length-packet follow-up is enabled with `define USB_TX_ZLP_EN.
module usb_tx_ep_sched #(
    parameter logic [3:0]  EP0_NUM = 4'd0,
    parameter logic [3:0]  EP1_NUM = 4'd1,
    parameter logic [3:0]  EP2_NUM = 4'd2,
    parameter logic [11:0] MAX0    = 12'd64,
    parameter logic [11:0] MAX1    = 12'd512,
    parameter logic [11:0] MAX2    = 12'd32,
    parameter int          CNT_W   = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    usb_tx_ep_sched_if.slave bus,
    output logic [1:0]       dbg_state
);
    localparam logic [1:0] SLOT_NONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        txact_q;
    logic [1:0]  act_q;
    logic [1:0]  sel_q;
    logic        cork_q;
    logic [11:0] len_out_q;
    logic [11:0] len_q;
    logic [11:0] pop_cnt;
    logic [11:0] pop_cnt_nx;
    logic        ovr_q;
    logic [15:0] wd_q;
    logic [2:0]  done_q;
    logic [2:0]  err_q;
    logic [2:0]  slot_1h;

    // Slot-indexed views padded to four entries; entry 3 is "no slot".
    logic [11:0] max_x  [4];
    logic [11:0] rnum_x [4];
    logic [3:0]  ena_x;
    logic [3:0]  rempty_x;

    logic [1:0]  lk_slot;
    logic        lk_ok;
    logic [11:0] lk_len;

    logic start, pop_ok, pop_ovr, fin_ok, fin_bad, ack_ok, ack_bad;

    assign max_x[0] = MAX0;
    assign max_x[1] = MAX1;
    assign max_x[2] = MAX2;
    assign max_x[3] = 12'd0;

    for (genvar g = 0; g < 3; g++) begin : g_rnum
        assign rnum_x[g] = 12'(bus.ep_rnum_i[g*(CNT_W+1) +: (CNT_W+1)]);
    end
    assign rnum_x[3] = 12'd0;

    assign ena_x    = {1'b0, bus.ep_ena_i};
    assign rempty_x = {1'b1, bus.ep_rempty_i};

`ifdef USB_TX_ZLP_EN
    logic [3:0] zlp_q;
    logic [3:0] eot_x;
    assign eot_x = {1'b0, bus.ep_eot_i};
`else
    logic [2:0] eot_unused;
    assign eot_unused = bus.ep_eot_i;
`endif

    always_comb begin
        lk_slot = SLOT_NONE;
        if (bus.endpt_i == EP0_NUM)      lk_slot = 2'd0;
        else if (bus.endpt_i == EP1_NUM) lk_slot = 2'd1;
        else if (bus.endpt_i == EP2_NUM) lk_slot = 2'd2;
        lk_ok  = ena_x[lk_slot] && !rempty_x[lk_slot];
        lk_len = (rnum_x[lk_slot] < max_x[lk_slot]) ? rnum_x[lk_slot] : max_x[lk_slot];
`ifdef USB_TX_ZLP_EN
        // A pending ZLP overrides the empty FIFO with a zero-length packet.
        if (zlp_q[lk_slot]) begin
            lk_ok  = ena_x[lk_slot];
            lk_len = 12'd0;
        end
`endif
    end

    // Handshake: the core raises txact_i for a whole data packet and asserts txpop_i for
    // each byte it takes; a pop is accepted (ep_rena_o) in the same cycle while the latched
    // length is not yet reached, and pops past that length are dropped and flagged.
    assign pop_cnt_nx = pop_cnt + {11'd0, pop_ok};
    assign slot_1h    = 3'b001 << act_q;

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        pop_ok  = 1'b0;
        pop_ovr = 1'b0;
        fin_ok  = 1'b0;
        fin_bad = 1'b0;
        ack_ok  = 1'b0;
        ack_bad = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.txact_i && !txact_q && sel_q != SLOT_NONE && !cork_q) begin
                    start   = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                pop_ok  = bus.txpop_i && (pop_cnt != len_q);
                pop_ovr = bus.txpop_i && (pop_cnt == len_q);
                if (!bus.txact_i) begin
                    if (pop_cnt_nx == len_q && !ovr_q && !pop_ovr) begin
                        fin_ok  = 1'b1;
                        state_d = WAIT_ACK;
                    end else begin
                        fin_bad = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_ACK: begin
                if (bus.ack_received_i) begin
                    ack_ok  = 1'b1;
                    state_d = IDLE;
                end else if (bus.ack_tout_i || wd_q == 16'hFFFF) begin
                    ack_bad = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            txact_q   <= 1'b0;
            act_q     <= 2'd0;
            sel_q     <= SLOT_NONE;
            cork_q    <= 1'b1;
            len_out_q <= 12'd0;
            len_q     <= 12'd0;
            pop_cnt   <= 12'd0;
            ovr_q     <= 1'b0;
            wd_q      <= 16'd0;
            done_q    <= 3'b000;
            err_q     <= 3'b000;
        end else begin
            txact_q <= bus.txact_i;
            done_q  <= 3'b000;
            err_q   <= 3'b000;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        act_q   <= sel_q;
                        len_q   <= len_out_q;
                        pop_cnt <= 12'd0;
                        ovr_q   <= 1'b0;
                    end else begin
                        cork_q    <= !lk_ok;
                        len_out_q <= lk_len;
                        sel_q     <= lk_slot;
                    end
                end
                SEND: begin
                    pop_cnt <= pop_cnt_nx;
                    wd_q    <= 16'd0;
                    if (pop_ovr) ovr_q <= 1'b1;
                    if (fin_bad) err_q <= slot_1h;
                end
                WAIT_ACK: begin
                    cork_q <= 1'b1;
                    wd_q   <= wd_q + 16'd1;
                    if (ack_ok)  done_q <= slot_1h;
                    if (ack_bad) err_q  <= slot_1h;
                end
                default: ;
            endcase
        end
    end

`ifdef USB_TX_ZLP_EN
    // A full-size packet that drained a FIFO at end of transfer owes the host a ZLP.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            zlp_q <= 4'd0;
        end else if (ack_ok) begin
            if (zlp_q[act_q] && len_q == 12'd0)
                zlp_q[act_q] <= 1'b0;
            else if (len_q == max_x[act_q] && rempty_x[act_q] && eot_x[act_q])
                zlp_q[act_q] <= 1'b1;
        end
    end
`endif

    assign bus.ep_rena_o   = pop_ok ? slot_1h : 3'b000;
    assign bus.sel_o       = sel_q;
    assign bus.txcork_o    = cork_q;
    assign bus.txdat_len_o = len_out_q;
    assign bus.pkt_done_o  = done_q;
    assign bus.pkt_err_o   = err_q;
    assign dbg_state       = state_q;

endmodule
